// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - command-driven counted shift burst controller with owned shift register
// Optional feature macro: SHIFT_SEQUENCER_ROTATE_EN (adds cmd_rotate, rotate instead of serial fill)
`timescale 1ns/1ps
module shift_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic             cmd_load,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
`ifdef SHIFT_SEQUENCER_ROTATE_EN
  input  logic             cmd_rotate,
`endif
  input  logic             hold,
  input  logic             serial_in,
  output logic             serial_out,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] remaining;
  logic             dir_r;
  logic             accept;
  logic             shift_en;
  logic             fill_left;
  logic             fill_right;

`ifdef SHIFT_SEQUENCER_ROTATE_EN
  logic rot_r;

  // Rotate mode recirculates the exiting bit instead of taking serial_in.
  assign fill_left  = rot_r ? q[WIDTH-1] : serial_in;
  assign fill_right = rot_r ? q[0]       : serial_in;

  // Rotate flag is captured with the rest of the command.
  always_ff @(posedge clk) begin
    if (rst)         rot_r <= 1'b0;
    else if (accept) rot_r <= cmd_rotate;
  end
`else
  assign fill_left  = serial_in;
  assign fill_right = serial_in;
`endif

  // Exiting end follows the latched direction, so it is the bit lost at the next shift.
  assign serial_out = dir_r ? q[WIDTH-1] : q[0];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and handshake/status decode.
  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    shift_en   = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          accept     = 1'b1;
          state_next = (cmd_count == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (!hold) begin
          shift_en = 1'b1;
          if (remaining == CNT_W'(1)) state_next = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: command capture on accept, one shift per unheld SHIFT cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      q         <= '0;
      remaining <= '0;
      dir_r     <= 1'b0;
    end else if (accept) begin
      dir_r     <= cmd_dir;
      remaining <= cmd_count;
      if (cmd_load) q <= cmd_data;
    end else if (shift_en) begin
      remaining <= remaining - CNT_W'(1);
      if (dir_r) q <= {q[WIDTH-2:0], fill_left};
      else       q <= {fill_right, q[WIDTH-1:1]};
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - scoreboard bench for shift_sequencer
`timescale 1ns/1ps
module tb_shift_sequencer;
  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_dir;
  logic          cmd_load;
  logic [W-1:0]  cmd_data;
  logic [CW-1:0] cmd_count;
`ifdef SHIFT_SEQUENCER_ROTATE_EN
  logic          cmd_rotate;
`endif
  logic          hold;
  logic          serial_in;
  logic          cmd_ready;
  logic          serial_out;
  logic [W-1:0]  q;
  logic          busy;
  logic          done;

  int           checks   = 0;
  int           failures = 0;
  logic [W-1:0] sb_q[$];
  logic [W-1:0] m_q;

  shift_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_dir    (cmd_dir),
    .cmd_load   (cmd_load),
    .cmd_data   (cmd_data),
    .cmd_count  (cmd_count),
`ifdef SHIFT_SEQUENCER_ROTATE_EN
    .cmd_rotate (cmd_rotate),
`endif
    .hold       (hold),
    .serial_in  (serial_in),
    .serial_out (serial_out),
    .q          (q),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] shift_model(input logic [W-1:0] v, input logic dir,
                                               input logic rot, input logic sin);
    logic b;
    if (dir) begin
      b = rot ? v[W-1] : sin;
      return {v[W-2:0], b};
    end
    b = rot ? v[0] : sin;
    return {b, v[W-1:1]};
  endfunction

  // Scoreboard: every done pulse retires the oldest expected result.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb_q.size() == 0) check_eq("sb_underflow", sb_q.size(), 1);
      else                  check_eq("sb_done_q", q, sb_q.pop_front());
    end
  end

  task automatic run_cmd(input logic dir, input logic load, input logic [W-1:0] data,
                         input logic [CW-1:0] count, input logic rot, input logic sin,
                         input int hold_at, input int hold_len);
    logic [W-1:0] cur;
    logic [W-1:0] fin;
    logic         h;
    int           sd;
    int           exp_k;
    cur = load ? data : m_q;
    fin = cur;
    for (int i = 0; i < int'(count); i++) fin = shift_model(fin, dir, rot, sin);
    sb_q.push_back(fin);
    cmd_valid = 1'b1;
    cmd_dir   = dir;
    cmd_load  = load;
    cmd_data  = data;
    cmd_count = count;
`ifdef SHIFT_SEQUENCER_ROTATE_EN
    cmd_rotate = rot;
`endif
    serial_in = sin;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_load  = 1'b0;
    sd    = 0;
    exp_k = int'(count) + hold_len;
    for (int k = 0; k <= exp_k; k++) begin
      @(negedge clk);
      check_eq("q_step", q, cur);
      check_eq("done_timing", done, k == exp_k);
      check_eq("busy_active", busy, 1);
      check_eq("ready_low", cmd_ready, 0);
      check_eq("serial_out", serial_out, dir ? cur[W-1] : cur[0]);
      if (k == exp_k) break;
      h    = (k >= hold_at) && (k < hold_at + hold_len);
      hold = h;
      @(posedge clk);
      if (!h && sd < int'(count)) begin
        cur = shift_model(cur, dir, rot, sin);
        sd++;
      end
    end
    hold = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("ready_back", cmd_ready, 1);
    check_eq("busy_back", busy, 0);
    check_eq("done_back", done, 0);
    check_eq("q_final", q, fin);
    m_q = fin;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_dir   = 1'b0;
    cmd_load  = 1'b0;
    cmd_data  = '0;
    cmd_count = '0;
`ifdef SHIFT_SEQUENCER_ROTATE_EN
    cmd_rotate = 1'b0;
`endif
    hold      = 1'b0;
    serial_in = 1'b0;
    m_q       = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_q", q, 0);
    check_eq("rst_ready", cmd_ready, 1);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("idle_q", q, 0);
      check_eq("idle_ready", cmd_ready, 1);
      check_eq("idle_busy", busy, 0);
      check_eq("idle_done", done, 0);
    end

    run_cmd(1'b1, 1'b1, 8'hA5, 4'd3, 1'b0, 1'b1, 0, 0);
    run_cmd(1'b0, 1'b1, 8'h81, 4'd2, 1'b0, 1'b0, 0, 0);
    run_cmd(1'b0, 1'b1, 8'h0F, 4'd0, 1'b0, 1'b0, 0, 0);
    run_cmd(1'b1, 1'b0, 8'h00, 4'd4, 1'b0, 1'b0, 1, 2);
    run_cmd(1'b0, 1'b1, 8'h96, 4'd11, 1'b0, 1'b1, 3, 1);
    run_cmd(1'b1, 1'b1, 8'h81, 4'd9, 1'b0, 1'b0, 0, 0);
`ifdef SHIFT_SEQUENCER_ROTATE_EN
    run_cmd(1'b1, 1'b1, 8'h81, 4'd9, 1'b1, 1'b0, 0, 0);
    check_eq("rot_left_9", m_q, 8'h03);
    run_cmd(1'b0, 1'b1, 8'h81, 4'd3, 1'b1, 1'b0, 2, 1);
`endif

    // Held cmd_valid across DONE must not cause a second accept.
    @(negedge clk);
    sb_q.push_back(8'h3C);
    cmd_valid = 1'b1;
    cmd_load  = 1'b1;
    cmd_data  = 8'h3C;
    cmd_count = 4'd0;
    @(posedge clk);
    @(negedge clk);
    check_eq("cnt0_done", done, 1);
    check_eq("cnt0_q", q, 8'h3C);
    check_eq("cnt0_ready", cmd_ready, 0);
    @(posedge clk);
    @(negedge clk);
    check_eq("no_double_done", done, 0);
    check_eq("no_double_ready", cmd_ready, 1);
    check_eq("no_double_busy", busy, 0);
    sb_q.push_back(8'h55);
    cmd_data = 8'h55;
    @(posedge clk);
    @(negedge clk);
    check_eq("second_done", done, 1);
    check_eq("second_q", q, 8'h55);
    cmd_valid = 1'b0;
    cmd_load  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("second_ready", cmd_ready, 1);

    // Reset in the middle of a count-5 burst abandons it without done.
    cmd_valid = 1'b1;
    cmd_load  = 1'b1;
    cmd_data  = 8'hFF;
    cmd_dir   = 1'b1;
    cmd_count = 4'd5;
    serial_in = 1'b0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_load  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("mid_busy", busy, 1);
    check_eq("mid_q", q, 8'hFC);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("midrst_q", q, 0);
    check_eq("midrst_ready", cmd_ready, 1);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_done", done, 0);
    rst = 1'b0;
    m_q = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_eq("post_rst_done", done, 0);
    end
    run_cmd(1'b0, 1'b0, 8'h00, 4'd2, 1'b0, 1'b1, 0, 0);

    check_eq("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
